// File: rtl/kij_pass_scheduler.sv
// rtl/kij_pass_scheduler.sv - sequences K*K weight-load/settle/run passes and a final psum readout
module kij_pass_scheduler #(
  parameter int                K            = 3,
  parameter int                KIJ_W        = 4,
  parameter int                LEN_NIJ      = 16,
  parameter int                ADDR_W       = 11,
  parameter logic [ADDR_W-1:0] WGT_BASE     = 11'h400,
  parameter int                SETTLE_CYC   = 5,
  parameter int                DONE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       layer_start,
  input  logic                       abort,
  output logic                       layer_busy,
  output logic                       layer_done,
  output logic                       error,
  output logic                       wgt_req,
  output logic [ADDR_W-1:0]          wgt_base_addr,
  input  logic                       wgt_ack,
  output logic [KIJ_W-1:0]           kij,
  output logic                       rchip,
  output logic                       core_start,
  input  logic                       core_done,
  output logic                       final_mem_read,
  output logic [$clog2(LEN_NIJ)-1:0] final_addr
);

  localparam int FA_W  = $clog2(LEN_NIJ);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int RUN_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [KIJ_W-1:0] KIJ_LAST    = KIJ_W'(K * K - 1);
  localparam logic [FA_W-1:0]  ADDR_LAST   = FA_W'(LEN_NIJ - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_SETTLE, S_RUN, S_DRAIN, S_FINAL, S_DONE
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [RUN_W-1:0] run_cnt;

  // Bank select follows kij directly so it can never move under an active core pass.
  assign rchip         = kij[0];
  assign wgt_base_addr = wgt_req ? WGT_BASE : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      kij            <= '0;
      layer_busy     <= 1'b0;
      layer_done     <= 1'b0;
      error          <= 1'b0;
      wgt_req        <= 1'b0;
      core_start     <= 1'b0;
      final_mem_read <= 1'b0;
      final_addr     <= '0;
      settle_cnt     <= '0;
      run_cnt        <= '0;
    end else if (abort) begin
      // Abort wins over every handshake seen this cycle; error is left as it stands.
      state          <= S_IDLE;
      kij            <= '0;
      layer_busy     <= 1'b0;
      layer_done     <= 1'b0;
      wgt_req        <= 1'b0;
      core_start     <= 1'b0;
      final_mem_read <= 1'b0;
      final_addr     <= '0;
      settle_cnt     <= '0;
      run_cnt        <= '0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (layer_start) begin
            state      <= S_LOAD_W;
            kij        <= '0;
            error      <= 1'b0;
            wgt_req    <= 1'b1;
            layer_busy <= 1'b1;
          end
        end
        S_LOAD_W: begin
          if (wgt_ack) begin
            wgt_req    <= 1'b0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            core_start <= 1'b1;
            run_cnt    <= '0;
            state      <= S_RUN;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        S_RUN: begin
          if (core_done) begin
            core_start <= 1'b0;
            state      <= S_DRAIN;
          end else if (run_cnt == RUN_LAST) begin
            error      <= 1'b1;
            core_start <= 1'b0;
            kij        <= '0;
            layer_busy <= 1'b0;
            state      <= S_IDLE;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end
        S_DRAIN: begin
          if (!core_done) begin
            if (kij == KIJ_LAST) begin
              final_mem_read <= 1'b1;
              final_addr     <= '0;
              state          <= S_FINAL;
            end else begin
              kij     <= kij + KIJ_W'(1);
              wgt_req <= 1'b1;
              state   <= S_LOAD_W;
            end
          end
        end
        S_FINAL: begin
          if (final_addr == ADDR_LAST) begin
            final_mem_read <= 1'b0;
            final_addr     <= '0;
            layer_done     <= 1'b1;
            state          <= S_DONE;
          end else begin
            final_addr <= final_addr + FA_W'(1);
          end
        end
        S_DONE: begin
          kij        <= '0;
          layer_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kij_pass_scheduler.sv
// tb/tb_kij_pass_scheduler.sv - scoreboard bench for kij_pass_scheduler
module tb_kij_pass_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        layer_start = 1'b0;
  logic        abort = 1'b0;
  logic        wgt_ack = 1'b0;
  logic        core_done = 1'b0;
  logic        layer_busy, layer_done, error, wgt_req, core_start, final_mem_read, rchip;
  logic [10:0] wgt_base_addr;
  logic [3:0]  kij;
  logic [3:0]  final_addr;

  always #5 clk = ~clk;

  kij_pass_scheduler dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .abort(abort),
    .layer_busy(layer_busy), .layer_done(layer_done), .error(error),
    .wgt_req(wgt_req), .wgt_base_addr(wgt_base_addr), .wgt_ack(wgt_ack),
    .kij(kij), .rchip(rchip), .core_start(core_start), .core_done(core_done),
    .final_mem_read(final_mem_read), .final_addr(final_addr)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int exp_kij_q[$];
  int exp_addr_q[$];
  int cyc = 0;
  int t_ack = -100;
  int last_start_cyc = 0;
  int n_start = 0, n_final = 0, n_done = 0;
  logic prev_cs = 1'b0;
  logic [3:0] prev_kij = '0;

  bit ack_en = 1'b1;
  bit done_en = 1'b1;
  int done_hold = 1;
  int suppress_kij = -1;
  int ack_cnt = 0, done_cnt = 0, done_left = 0;

  // Monitor first, then the loader and core responders, all 1 time unit after the edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset) begin
      if (core_start && !prev_cs) begin
        int e;
        e = (exp_kij_q.size() > 0) ? exp_kij_q.pop_front() : -1;
        check("kij", 32'(kij), e);
        check("rchip", 32'(rchip), e & 1);
        check("settle", cyc - t_ack, 6);
        n_start++;
        last_start_cyc = cyc;
      end
      if (final_mem_read) begin
        int e;
        e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : -1;
        check("final_addr", 32'(final_addr), e);
        n_final++;
      end
      if (layer_done) n_done++;
      if (wgt_req) check("wgt_base", 32'(wgt_base_addr), 32'h400);
      if (cyc == t_ack) check("wgt_req_drop", 32'(wgt_req), 0);
      if (core_done && !abort) check("drain_hold", 32'(kij), 32'(prev_kij));
    end

    if (wgt_ack) wgt_ack = 1'b0;
    else if (ack_en && wgt_req) begin
      if (ack_cnt == 2) begin
        wgt_ack = 1'b1;
        ack_cnt = 0;
        t_ack = cyc + 1;
      end else ack_cnt++;
    end else ack_cnt = 0;

    if (done_left > 0) begin
      done_left--;
      if (done_left == 0) core_done = 1'b0;
    end else if (done_en && core_start && int'(kij) != suppress_kij) begin
      if (done_cnt == 19) begin
        core_done = 1'b1;
        done_left = done_hold;
        done_cnt = 0;
      end else done_cnt++;
    end else done_cnt = 0;

    prev_cs = core_start;
    prev_kij = kij;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic push_layer(input int nk, input bit with_final);
    for (int i = 0; i < nk; i++) exp_kij_q.push_back(i);
    if (with_final) for (int a = 0; a < 16; a++) exp_addr_q.push_back(a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(layer_busy), 0);
    check({tag, "_ldone"}, 32'(layer_done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_wreq"}, 32'(wgt_req), 0);
    check({tag, "_wbase"}, 32'(wgt_base_addr), 0);
    check({tag, "_kij"}, 32'(kij), 0);
    check({tag, "_rchip"}, 32'(rchip), 0);
    check({tag, "_cstart"}, 32'(core_start), 0);
    check({tag, "_fmr"}, 32'(final_mem_read), 0);
    check({tag, "_faddr"}, 32'(final_addr), 0);
  endtask

  task automatic run_full(input string tag, input int budget, input int poke_kij);
    int s0, f0, d0;
    bit poked;
    s0 = n_start; f0 = n_final; d0 = n_done; poked = 1'b0;
    push_layer(9, 1'b1);
    pulse_start();
    check({tag, "_err_clr"}, 32'(error), 0);
    check({tag, "_busy_on"}, 32'(layer_busy), 1);
    for (int i = 0; i < budget && n_done == d0; i++) begin
      if (!poked && poke_kij >= 0 && core_start && int'(kij) == poke_kij) begin
        layer_start = 1'b1;
        poked = 1'b1;
      end
      tick();
      layer_start = 1'b0;
    end
    check({tag, "_done"}, n_done - d0, 1);
    check({tag, "_busy_in_done"}, 32'(layer_busy), 1);
    check({tag, "_starts"}, n_start - s0, 9);
    check({tag, "_finals"}, n_final - f0, 16);
    check({tag, "_kq"}, exp_kij_q.size(), 0);
    check({tag, "_aq"}, exp_addr_q.size(), 0);
    tick();
    check({tag, "_busy_off"}, 32'(layer_busy), 0);
    check({tag, "_kij0"}, 32'(kij), 0);
  endtask

  initial begin
    int d0, s0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("rst");
    reset = 1'b1;
    tick();

    run_full("full", 1000, -1);

    done_hold = 10;
    run_full("robust", 1500, 3);
    done_hold = 1;

    // Timeout at kij 4
    suppress_kij = 4;
    push_layer(5, 1'b0);
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 3000 && !error; i++) tick();
    check("to_error", 32'(error), 1);
    check("to_latency", cyc - last_start_cyc, 1024);
    check("to_kij", 32'(kij), 0);
    check("to_cstart", 32'(core_start), 0);
    check("to_busy", 32'(layer_busy), 0);
    check("to_kq", exp_kij_q.size(), 0);
    tick();
    check("to_nodone", n_done - d0, 0);
    check("to_sticky", 32'(error), 1);
    suppress_kij = -1;
    run_full("after_to", 1000, -1);

    // Abort in RUN at kij 2 with core_done in the same cycle
    push_layer(3, 1'b0);
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 500 && !(core_start && kij == 4'd2); i++) tick();
    done_en = 1'b0;
    check("ab_reach", 32'(kij), 2);
    repeat (3) tick();
    s0 = n_start;
    abort = 1'b1;
    core_done = 1'b1;
    tick();
    abort = 1'b0;
    core_done = 1'b0;
    check("ab_cstart", 32'(core_start), 0);
    check("ab_kij", 32'(kij), 0);
    check("ab_busy", 32'(layer_busy), 0);
    check("ab_wreq", 32'(wgt_req), 0);
    check("ab_fmr", 32'(final_mem_read), 0);
    repeat (10) tick();
    check("ab_idle", 32'(layer_busy), 0);
    check("ab_nostart", n_start - s0, 0);
    check("ab_nodone", n_done - d0, 0);
    check("ab_kq", exp_kij_q.size(), 0);
    done_en = 1'b1;

    // Async reset mid-FINAL
    push_layer(9, 1'b1);
    pulse_start();
    for (int i = 0; i < 1000 && !(final_mem_read && final_addr == 4'd7); i++) tick();
    check("rf_reach", 32'(final_addr), 7);
    #3;
    reset = 1'b0;
    #1;
    check_zero("rf");
    #3;
    reset = 1'b1;
    exp_kij_q.delete();
    exp_addr_q.delete();
    tick();
    run_full("after_rst", 1000, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kij_pass_scheduler.md
Name: kij_pass_scheduler

Overview:
- Sequences one full convolution layer on the core controller datapath without testbench intervention.
- For each of the K*K kernel positions (kij), in order:
  - requests a weight-tile load into the activation/weight SRAM weight region;
  - waits a settle interval, pulses the core start/done handshake;
  - alternates the psum bank select (rchip).
- After the last kij, issues a final psum-memory readout sweep and signals layer completion.
- Sits between the top-level host/loader and core_ctrl, replacing the hand-driven start/kij/rchip/final_mem_read sequence.

Parameters:
- K, 3, kernel dimension; the layer runs K*K passes.
- KIJ_W, 4, width of the kij index (must hold K*K-1).
- LEN_NIJ, 16, number of output pixels swept during final readout.
- ADDR_W, 11, SRAM address width.
- WGT_BASE, 11'h400, SRAM base address of the weight region.
- SETTLE_CYC, 5, idle cycles between weight-load ack and core start.
- DONE_TIMEOUT, 1024, maximum cycles in RUN before a timeout error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- layer_start  in  1  one-cycle request to run a layer; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- layer_busy  out  1  high in every state except IDLE.
- layer_done  out  1  one-cycle pulse on completion.
- error  out  1  sticky timeout flag; cleared by reset or by the next accepted layer_start.
- wgt_req  out  1  weight-load request; held until wgt_ack.
- wgt_base_addr  out  ADDR_W  equals WGT_BASE, valid while wgt_req is high.
- wgt_ack  in  1  loader finished writing the kij tile.
- kij  out  KIJ_W  current kernel position.
- rchip  out  1  psum bank select; equals kij[0].
- core_start  out  1  level start to core_ctrl.
- core_done  in  1  core pass complete.
- final_mem_read  out  1  high during the readout sweep.
- final_addr  out  $clog2(LEN_NIJ)  readout index.

Behaviour:
- Reset (async, reset=0): state=IDLE, kij=0, all outputs 0, error=0, all counters 0.
- States: IDLE, LOAD_W, SETTLE, RUN, DRAIN, FINAL, DONE.
- IDLE:
  - layer_start=1 → LOAD_W next cycle; kij=0, error cleared.
  - layer_start in any other state is ignored.
- LOAD_W:
  - wgt_req=1.
  - wgt_ack sampled high → wgt_req=0 next cycle, go to SETTLE with the settle counter at 0.
  - wgt_ack in any other state is ignored.
- SETTLE: count SETTLE_CYC cycles, then RUN. core_start rises exactly SETTLE_CYC+1 cycles after the ack edge.
- RUN:
  - core_start=1; run counter increments every cycle.
  - core_done=1 → DRAIN.
  - Counter reaches DONE_TIMEOUT with no done → error=1, core_start=0, state=IDLE, kij=0. No layer_done is issued.
- DRAIN:
  - core_start=0; wait for core_done=0.
  - If kij==K*K-1 → FINAL; otherwise kij+1 → LOAD_W.
  - A core_done held high keeps the block in DRAIN; no timeout applies here.
- FINAL: final_mem_read=1, final_addr increments 0..LEN_NIJ-1, one per cycle (LEN_NIJ cycles), then DONE.
- DONE: layer_done=1 for one cycle, kij=0, → IDLE.
- rchip: combinationally kij[0]; it changes only when kij changes, never while core_start=1.
- abort=1 in any state, next cycle:
  - state=IDLE, kij=0;
  - wgt_req, core_start and final_mem_read all 0;
  - error unchanged; no layer_done.
  - abort takes priority over every other transition in the same cycle, including wgt_ack and core_done.
- Simultaneous layer_start and abort in IDLE: stay in IDLE.
- All outputs are registered except rchip and wgt_base_addr.

Test Plan:
- Full layer: layer_start; wgt_ack 3 cycles after each wgt_req; core_done 20 cycles after core_start for 1 cycle → kij 0..8 in order; rchip 0,1,0,...,0; nine start pulses; final_mem_read high for exactly 16 cycles with final_addr 0..15; one layer_done; layer_busy low afterwards.
- Settle timing: wgt_ack at cycle T → core_start first high at T+6; wgt_req low at T+1.
- Timeout: core_done never asserted at kij=4 → error=1 exactly 1024 cycles after core_start rose; state IDLE, kij=0, no layer_done. A later layer_start clears error and runs a full layer.
- Abort mid-RUN at kij=2, with core_done asserted in the same cycle → next cycle core_start=0, kij=0, layer_busy=0; no kij advance.
- Async reset asserted mid-FINAL (final_addr=7), deasserted off-edge → all outputs 0 immediately; a fresh layer_start completes normally.
- Robustness: layer_start pulsed during RUN is ignored (kij sequence unchanged); core_done held high for 10 cycles keeps DRAIN, and kij advances only after it falls.
